// File: rtl/sseg_pkg.sv
// Shared constants and segment decode for the seven-segment scan controller.
// Segment patterns are active low, ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam logic [7:0] SSEG_OFF  = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_sseg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Digit slot timing: a prescaler that steps the scanned digit index.
// frame_start marks the first cycle of digit 0's slot.
module sseg_scan_timer #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 6250
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          frame_start,
    output logic [$clog2(NUM_DIGITS)-1:0] idx
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] pre_cnt;
    logic          slot_tick;

    assign slot_tick   = (pre_cnt == PRE_MAX);
    assign frame_start = (pre_cnt == '0) && (idx == '0);

    // Prescaler wraps at the slot tick, which also steps the digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (slot_tick) begin
            pre_cnt <= '0;
            idx     <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode seven-segment controller with frame-coherent
// capture, leading-zero suppression, blanking, blinking and PWM dimming.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 6250,
    parameter int BLINK_LOG2 = 24,
    parameter int PWM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_en,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int IW = $clog2(NUM_DIGITS);

    logic                    frame_start;
    logic [IW-1:0]           idx;

    logic [4*NUM_DIGITS-1:0] sh_hex;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_lz;

    logic [4*NUM_DIGITS-1:0] eff_hex;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic [NUM_DIGITS-1:0]   eff_blank;
    logic [NUM_DIGITS-1:0]   eff_blink;
    logic                    eff_lz;

    logic [3:0]              dig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   sup;

    logic [BLINK_LOG2-1:0]   blink_cnt;
    logic [PWM_BITS-1:0]     pwm_cnt;

    logic                    pwm_on;
    logic                    cur_sup;
    logic                    cur_dp;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [7:0]              sseg_nxt;

    sseg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .idx         (idx)
    );

    // Bypass the shadows in the capture cycle so digit 0 of a new frame
    // already shows the freshly captured inputs.
    always_comb begin
        eff_hex   = frame_start ? hex_in   : sh_hex;
        eff_dp    = frame_start ? dp_in    : sh_dp;
        eff_blank = frame_start ? blank_in : sh_blank;
        eff_blink = frame_start ? blink_in : sh_blink;
        eff_lz    = frame_start ? lz_en    : sh_lz;
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign dig[k] = eff_hex[4*k +: 4];
    end

    // A digit is suppressed while it and every higher digit are zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        sup      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (dig[k] == 4'h0);
            sup[k]   = eff_lz && zero_run;
        end
        sup[0] = 1'b0;
    end

    // Shadow capture once per frame, at the start of digit 0's slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_hex   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            sh_blink <= '0;
            sh_lz    <= 1'b0;
        end else if (frame_start) begin
            sh_hex   <= hex_in;
            sh_dp    <= dp_in;
            sh_blank <= blank_in;
            sh_blink <= blink_in;
            sh_lz    <= lz_en;
        end
    end

    // Free-running blink and PWM counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
        end
    end

    // Decide whether the current digit is lit and what it shows.
    always_comb begin
        pwm_on  = (pwm_cnt < brightness) || (&brightness);
        cur_sup = sup[idx];
        cur_dp  = eff_dp[idx];
        dark    = eff_blank[idx]
                | (eff_blink[idx] & blink_cnt[BLINK_LOG2-1])
                | ~pwm_on
                | (cur_sup & ~cur_dp);
        an_nxt   = '1;
        sseg_nxt = SSEG_OFF;
        if (!dark) begin
            an_nxt   = ~(NUM_DIGITS'(1) << idx);
            sseg_nxt = {~cur_dp,
                        cur_sup ? SEG_BLANK : hex_to_sseg(dig[idx])};
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            sseg       <= SSEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            sseg       <= sseg_nxt;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: a time-based reference model
// pushes expected pin states, a monitor pops and compares each cycle.
module tb_sseg_scan_ctrl;

    localparam int N  = 8;
    localparam int P  = 4;
    localparam int BL = 6;
    localparam int PB = 4;
    localparam int F  = N * P;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4*N-1:0] hex_in = '0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  blank_in = '0;
    logic [N-1:0]  blink_in = '0;
    logic          lz_en = 1'b0;
    logic [PB-1:0] brightness = '1;
    logic [N-1:0]  an;
    logic [7:0]    sseg;
    logic          frame_tick;

    int total = 0;
    int bad = 0;
    int t = 0;

    logic [16:0]   q[$];

    logic [4*N-1:0] sh_hex;
    logic [N-1:0]  sh_dp;
    logic [N-1:0]  sh_blank;
    logic [N-1:0]  sh_blink;
    logic          sh_lz;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .BLINK_LOG2 (BL),
        .PWM_BITS   (PB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .lz_en      (lz_en),
        .brightness (brightness),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    // Expected {frame_tick, an, sseg} after edge tt, counted from reset release.
    function automatic logic [16:0] model(int tt);
        int         k;
        bit         ph;
        int         pwm;
        bit         pwm_on;
        bit         sup;
        bit         dp;
        bit         dark;
        bit         ft;
        logic [7:0] a;
        logic [7:0] s;
        logic [3:0] d;
        k      = (tt / P) % N;
        ph     = ((tt % (1 << BL)) >= (1 << (BL - 1)));
        pwm    = tt % (1 << PB);
        pwm_on = (brightness == 4'hF) || (pwm < int'(brightness));
        sup    = sh_lz && (k != 0) && ((sh_hex >> (4 * k)) == 0);
        dp     = sh_dp[k];
        dark   = sh_blank[k] || (sh_blink[k] && ph) || !pwm_on
                 || (sup && !dp);
        ft     = ((tt % F) == 0);
        d      = 4'((sh_hex >> (4 * k)) & 32'hF);
        if (dark) begin
            a = 8'hFF;
            s = 8'hFF;
        end else begin
            a = ~(8'(1) << k);
            s = {~dp, sup ? 7'h7F : seg_tab[d]};
        end
        return {ft, a, s};
    endfunction

    // One cycle of stimulus: inputs already set, clock low.
    task automatic step();
        if ((t % F) == 0) begin
            sh_hex   = hex_in;
            sh_dp    = dp_in;
            sh_blank = blank_in;
            sh_blink = blink_in;
            sh_lz    = lz_en;
        end
        q.push_back(model(t));
        t++;
        @(negedge clk);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic chk_reset(string tag);
        total++;
        if (an !== 8'hFF || sseg !== 8'hFF || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL %s: an=%h sseg=%h ft=%b want an=ff sseg=ff ft=0",
                     tag, an, sseg, frame_tick);
        end
    endtask

    // Called just after a negedge with the scoreboard queue drained.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1 chk_reset("reset_immediate");
        @(posedge clk);
        @(negedge clk);
        chk_reset("reset_held");
        #1 reset = 1'b0;
        t = 0;
    endtask

    // Monitor: compare the pins against the oldest expectation.
    initial begin
        logic [16:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_v = q.pop_front();
                total++;
                if ({frame_tick, an, sseg} !== exp_v) begin
                    bad++;
                    $display("FAIL scan: ft=%b an=%h sseg=%h want ft=%b an=%h sseg=%h",
                             frame_tick, an, sseg,
                             exp_v[16], exp_v[15:8], exp_v[7:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();

        hex_in = 32'h87654321;
        brightness = 4'hF;
        run(2 * F);

        hex_in = 32'h000000A0;
        dp_in = 8'h04;
        lz_en = 1'b1;
        run(2 * F);

        lz_en = 1'b0;
        dp_in = 8'h00;
        brightness = 4'd4;
        run(F);
        brightness = 4'd0;
        run(F);

        brightness = 4'hF;
        blink_in = 8'h04;
        run(4 * F);

        blink_in = 8'h00;
        hex_in = 32'h11111111;
        run(F + 3 * P + 2);
        hex_in = 32'h22222222;
        run(2 * F);

        blank_in = 8'h00;
        run(5);
        do_reset();

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0)
                hex_in = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 15) == 0) dp_in = 8'($urandom);
            if ($urandom_range(0, 15) == 0)
                blank_in = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) blink_in = 8'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 31) == 0)
                brightness = 4'($urandom_range(0, 15));
            step();
            if (i == 777) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
